// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues imem requests, buffers responses in an in-order queue.
// Build option IF_PQ_BYPASS_EN: a live response into an empty queue reaches decode in the same cycle.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        redirect,
    input  logic [31:0] newPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] Ins,
    output logic [31:0] nextPC
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [1:0]    out_cnt_q, out_cnt_d;
    logic [1:0]    disc_cnt_q, disc_cnt_d;
    logic          hold_q, hold_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   ent_ins_q [DEPTH];
    logic [31:0]   ent_ins_d [DEPTH];
    logic [31:0]   ent_npc_q [DEPTH];
    logic [31:0]   ent_npc_d [DEPTH];

    logic          grant;
    logic          resp_live;
    logic          head_valid;
    logic          bypass_take;
    logic          push;
    logic          pop;
    logic [SW-1:0] reserved;
    logic [31:0]   resp_npc;
    logic [31:0]   target_pc;

    assign target_pc  = newPC & 32'hFFFF_FFFC;
    assign head_valid = (count_q != '0);
    assign reserved   = SW'(count_q) + SW'(out_cnt_q);

    // Every outstanding request already owns a queue slot, so responses can never overflow it.
    assign imem_req  = !RST && !hold_q && (state_q == FETCH)
                     && (reserved < SW'(DEPTH)) && (out_cnt_q < 2'(MAX_OUT));
    assign imem_addr = fpc_q;
    assign grant     = imem_req && imem_gnt;
    assign resp_live = imem_rvalid && (disc_cnt_q == 2'd0) && !redirect;

    // Live outstanding requests were granted back-to-back ending at fpc-4; the oldest is fpc - 4*out_cnt.
    assign resp_npc = fpc_q - {28'd0, out_cnt_q, 2'b00} + 32'd4;

    always_comb begin
        ins_valid   = head_valid;
        Ins         = head_valid ? ent_ins_q[rd_ptr_q] : 32'd0;
        nextPC      = head_valid ? ent_npc_q[rd_ptr_q] : 32'd0;
        bypass_take = 1'b0;
`ifdef IF_PQ_BYPASS_EN
        if (!head_valid && resp_live) begin
            ins_valid   = 1'b1;
            Ins         = imem_rdata;
            nextPC      = resp_npc;
            bypass_take = ins_ready;
        end
`endif
    end

    assign pop  = head_valid && ins_ready && !redirect;
    assign push = resp_live && !bypass_take;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_entry
            assign ent_ins_d[gi] = (push && wr_ptr_q == PW'(gi)) ? imem_rdata : ent_ins_q[gi];
            assign ent_npc_d[gi] = (push && wr_ptr_q == PW'(gi)) ? resp_npc   : ent_npc_q[gi];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        out_cnt_d  = out_cnt_q + {1'b0, grant} - {1'b0, imem_rvalid};
        disc_cnt_d = disc_cnt_q;
        hold_d     = redirect;
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        if (grant) begin
            fpc_d = fpc_q + 32'd4;
        end
        if (imem_rvalid && disc_cnt_q != 2'd0) begin
            disc_cnt_d = disc_cnt_q - 2'd1;
        end
        if (state_q == DRAIN && disc_cnt_d == 2'd0) begin
            state_d = FETCH;
        end
        // Everything still in flight after this cycle's updates belongs to the old stream.
        if (redirect) begin
            fpc_d      = target_pc;
            disc_cnt_d = out_cnt_d;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            state_d    = (out_cnt_d != 2'd0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= FETCH;
            fpc_q      <= RESET_PC;
            out_cnt_q  <= 2'd0;
            disc_cnt_q <= 2'd0;
            hold_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
            hold_q     <= hold_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        ent_ins_q <= ent_ins_d;
        ent_npc_q <= ent_npc_d;
    end

    assert property (@(posedge CLK) disable iff (RST) !(push && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue: a memory model with random grant and in-order latency feeds the DUT;
// each consumed instruction is compared with the program-order PC stream implied by reset and redirects.
`timescale 1ns/1ps
module tb_if_prefetch_queue;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK;
    logic        RST;
    logic        redirect;
    logic [31:0] newPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] Ins;
    logic [31:0] nextPC;

    if_prefetch_queue #(
        .DEPTH    (4),
        .MAX_OUT  (2),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .redirect    (redirect),
        .newPC       (newPC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .Ins         (Ins),
        .nextPC      (nextPC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_consumed = 0;
    logic [31:0] exp_q [$];
    logic [31:0] gnt_log [$];
    logic [31:0] pend_addr [$];
    int          pend_due [$];
    logic [31:0] mon_pc;

    bit          rst_v, redir_v, rdy_v;
    logic [31:0] npc_v;
    int          gnt_pct, lat_min, lat_max;
    bit          req_p, gnt_p, redir_p, rst_p;
    logic [31:0] addr_p;

    // Memory content: odd-constant multiply is a bijection, so every address returns a distinct word.
    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < gnt_log.size()) return gnt_log[i];
        return 32'hDEAD_DEAD;
    endfunction

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(pc + 32'(4 * i));
    endtask

    // One clock cycle: drive inputs at the falling edge, then grant against the settled request.
    task automatic step();
        @(negedge CLK);
        cyc++;
        RST       = rst_v;
        redirect  = redir_v && !rst_v;
        newPC     = npc_v;
        ins_ready = rdy_v;
        if (rst_v) begin
            pend_addr.delete();
            pend_due.delete();
            sb_restart(RESET_PC);
        end else if (redir_v) begin
            sb_restart(npc_v & 32'hFFFF_FFFC);
        end
        if (!rst_v && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ins_of(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt = ($urandom_range(99, 0) < gnt_pct);
        #1;
        if (rst_v) check("reset_req", imem_req == 1'b0, 32'(imem_req), 32'd0);
        if (rst_v && rst_p) begin
            check("reset_valid", ins_valid == 1'b0, 32'(ins_valid), 32'd0);
            check("reset_ins", Ins == 32'd0, Ins, 32'd0);
            check("reset_npc", nextPC == 32'd0, nextPC, 32'd0);
            check("reset_addr", imem_addr == RESET_PC, imem_addr, RESET_PC);
        end
        if (!rst_v && !rst_p && !redir_p && req_p && !gnt_p) begin
            check("req_hold", imem_req == 1'b1, 32'(imem_req), 32'd1);
            check("addr_hold", imem_addr == addr_p, imem_addr, addr_p);
        end
        if (imem_req && imem_gnt) begin
            gnt_log.push_back(imem_addr);
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        end
        req_p   = imem_req;
        gnt_p   = imem_gnt;
        addr_p  = imem_addr;
        redir_p = redirect;
        rst_p   = rst_v;
    endtask

    task automatic do_reset();
        rst_v   = 1'b1;
        redir_v = 1'b0;
        repeat (2) step();
        rst_v = 1'b0;
        gnt_log.delete();
    endtask

    // Monitor: every accepted head is checked against the next expected program-order PC.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (!RST && ins_valid && ins_ready && !redirect) begin
                mon_pc = exp_q.pop_front();
                check("ins", Ins == ins_of(mon_pc), Ins, ins_of(mon_pc));
                check("next_pc", nextPC == mon_pc + 32'd4, nextPC, mon_pc + 32'd4);
                $display("txn %0d cyc=%0d nextPC=%h Ins=%h", n_consumed, cyc, nextPC, Ins);
                n_consumed++;
                if (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
            end
        end
    end

    initial begin
        int c0;
        int idx;
        RST = 1'b1; redirect = 1'b0; newPC = 32'd0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0; ins_ready = 1'b0;
        rst_v = 1'b1; redir_v = 1'b0; npc_v = 32'd0; rdy_v = 1'b0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        req_p = 1'b0; gnt_p = 1'b0; redir_p = 1'b0; rst_p = 1'b0; addr_p = 32'd0;

        // Reset, then straight-line fetch at full rate.
        repeat (3) step();
        rst_v = 1'b0;
        rdy_v = 1'b1;
        gnt_log.delete();
        step();
        check("first_req", imem_req == 1'b1, 32'(imem_req), 32'd1);
        check("first_addr", imem_addr == RESET_PC, imem_addr, RESET_PC);
        check("first_valid", ins_valid == 1'b0, 32'(ins_valid), 32'd0);
        repeat (3) step();
        c0 = n_consumed;
        repeat (8) step();
        check("throughput", n_consumed - c0 == 8, 32'(n_consumed - c0), 32'd8);
        for (int i = 0; i < 6; i++) check("addr_seq", log_at(i) == 32'(4 * i), log_at(i), 32'(4 * i));

        // Back-pressure: queue fills, requests stop, then drain and resume at 0x10.
        rdy_v = 1'b0;
        do_reset();
        repeat (12) step();
        check("fill_grants", gnt_log.size() == 4, 32'(gnt_log.size()), 32'd4);
        check("fill_req_low", imem_req == 1'b0, 32'(imem_req), 32'd0);
        check("fill_valid", ins_valid == 1'b1, 32'(ins_valid), 32'd1);
        rdy_v = 1'b1;
        c0 = n_consumed;
        repeat (10) step();
        check("resume_addr", log_at(4) == 32'h10, log_at(4), 32'h10);
        check("drain_pops", n_consumed - c0 >= 4, 32'(n_consumed - c0), 32'd4);

        // Redirect with two stale requests in flight.
        do_reset();
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 20 && pend_addr.size() != 2; i++) step();
        check("two_outstanding", pend_addr.size() == 2, 32'(pend_addr.size()), 32'd2);
        redir_v = 1'b1; npc_v = 32'h0000_1003;
        step();
        redir_v = 1'b0;
        idx = gnt_log.size();
        step();
        check("redir_req_low", imem_req == 1'b0, 32'(imem_req), 32'd0);
        check("redir_flush", ins_valid == 1'b0, 32'(ins_valid), 32'd0);
        for (int i = 0; i < 30 && gnt_log.size() <= idx; i++) step();
        check("redir_addr", log_at(idx) == 32'h1000, log_at(idx), 32'h1000);
        repeat (15) step();

        // Redirect coincident with a response while decode is ready.
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (6) step();
        redir_v = 1'b1; npc_v = 32'h0000_2000;
        step();
        redir_v = 1'b0;
        step();
        check("resp_drop_valid", ins_valid == 1'b0, 32'(ins_valid), 32'd0);
        check("resp_drop_req", imem_req == 1'b0, 32'(imem_req), 32'd0);
        repeat (10) step();

        // Address wrap at the top of the 32-bit space.
        redir_v = 1'b1; npc_v = 32'hFFFF_FFF8;
        step();
        redir_v = 1'b0;
        idx = gnt_log.size();
        repeat (12) step();
        check("wrap_addr0", log_at(idx) == 32'hFFFF_FFF8, log_at(idx), 32'hFFFF_FFF8);
        check("wrap_addr1", log_at(idx + 1) == 32'hFFFF_FFFC, log_at(idx + 1), 32'hFFFF_FFFC);
        check("wrap_addr2", log_at(idx + 2) == 32'h0000_0000, log_at(idx + 2), 32'h0000_0000);

        // Random grant, latency, decode stalls, redirects and one mid-burst reset.
        do_reset();
        gnt_pct = 70; lat_min = 1; lat_max = 5;
        c0 = n_consumed;
        for (int i = 0; i < 3000; i++) begin
            rdy_v   = ($urandom_range(99, 0) < 75);
            redir_v = ($urandom_range(99, 0) < 3);
            npc_v   = $urandom;
            rst_v   = (i == 1500 || i == 1501);
            step();
        end
        rst_v = 1'b0; redir_v = 1'b0;
        repeat (5) step();
        check("random_progress", n_consumed - c0 >= 100, 32'(n_consumed - c0), 32'd100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
